// File: rtl/sound_player_pkg.sv
// Shared game constants: sound event codes, player FSM encoding, tone frequencies.
// Also holds the elaboration-time half-period helper used by the sound player.
package sound_player_pkg;

  typedef logic [2:0] snd_code_t;

  localparam snd_code_t SND_NONE  = 3'd0;
  localparam snd_code_t SND_HIT1  = 3'd1;
  localparam snd_code_t SND_HIT2  = 3'd2;
  localparam snd_code_t SND_BREAK = 3'd3;
  localparam snd_code_t SND_LOST  = 3'd4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  localparam int FREQ_HIT1  = 440;
  localparam int FREQ_HIT2  = 660;
  localparam int FREQ_BREAK = 880;
  localparam int FREQ_LOST  = 220;

  localparam int HP_W  = 20;
  localparam int DUR_W = 26;

  function automatic int half_period(input int clk_hz, input int freq);
    return clk_hz / (2 * freq);
  endfunction

  function automatic logic is_tone(input snd_code_t code);
    return (code >= SND_HIT1) && (code <= SND_LOST);
  endfunction

endpackage

// File: rtl/sound_player_tone_gen.sv
// Square-wave generator: wave toggles every half_period cycles while enabled.
// One-cycle register latency; clear forces counter and wave to zero, no backpressure.
module tone_gen
  import sound_player_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [HP_W-1:0] half_period,
  output logic            wave
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            wave_q, wave_d;

  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (clear) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (enable) begin
      if (cnt_q == half_period - HP_W'(1)) begin
        cnt_d  = '0;
        wave_d = ~wave_q;
      end else begin
        cnt_d = cnt_q + HP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/sound_player.sv
// Event-driven tone player: 2-cycle latency from sound_code change to busy/code_out.
// No backpressure; the latest trigger always restarts the tone.
module sound_player
  import sound_player_pkg::*;
#(
  parameter int CLK_HZ      = 25000000,
  parameter int TONE_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sound_code,
  input  logic       erase_enable,
  output logic       speaker,
  output logic       busy,
  output logic [2:0] code_out
);

  localparam int HP1 = half_period(CLK_HZ, FREQ_HIT1);
  localparam int HP2 = half_period(CLK_HZ, FREQ_HIT2);
  localparam int HP3 = half_period(CLK_HZ, FREQ_BREAK);
  localparam int HP4 = half_period(CLK_HZ, FREQ_LOST);

  localparam logic [HP_W-1:0]  HP1_V          = HP_W'(HP1);
  localparam logic [HP_W-1:0]  HP2_V          = HP_W'(HP2);
  localparam logic [HP_W-1:0]  HP3_V          = HP_W'(HP3);
  localparam logic [HP_W-1:0]  HP4_V          = HP_W'(HP4);
  localparam logic [DUR_W-1:0] DUR_SHORT_LAST = DUR_W'(TONE_CYCLES - 1);
  localparam logic [DUR_W-1:0] DUR_LONG_LAST  = DUR_W'(4 * TONE_CYCLES - 1);

  // A half period under 2 cycles cannot produce a square wave.
  if (HP1 < 2 || HP2 < 2 || HP3 < 2 || HP4 < 2 ||
      HP4 > (2 ** HP_W) - 1) begin : g_hp_check
    $error("sound_player: tone half period out of range for CLK_HZ");
  end

  snd_code_t        sound_code_q, prev_code_q;
  logic             erase_q, erase_prev_q;
  logic [0:0]       state_q, state_d;
  snd_code_t        code_q, code_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [DUR_W-1:0] dur_last;
  logic [HP_W-1:0]  hp_sel;
  logic             trigger;
  logic             tone_clear;
  logic             wave;

  assign trigger = is_tone(sound_code_q) &&
                   ((sound_code_q != prev_code_q) || (erase_q && !erase_prev_q));

  assign dur_last = (code_q == SND_LOST) ? DUR_LONG_LAST : DUR_SHORT_LAST;

  always_comb begin
    case (code_q)
      SND_HIT2:  hp_sel = HP2_V;
      SND_BREAK: hp_sel = HP3_V;
      SND_LOST:  hp_sel = HP4_V;
      default:   hp_sel = HP1_V;
    endcase
  end

  // Trigger is checked first so a retrigger on terminal count restarts cleanly.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    dur_d      = dur_q;
    tone_clear = 1'b0;
    if (trigger) begin
      state_d    = ST_PLAY;
      code_d     = sound_code_q;
      dur_d      = '0;
      tone_clear = 1'b1;
    end else if (state_q == ST_PLAY) begin
      if (dur_q == dur_last) begin
        state_d    = ST_IDLE;
        code_d     = SND_NONE;
        dur_d      = '0;
        tone_clear = 1'b1;
      end else begin
        dur_d = dur_q + DUR_W'(1);
      end
    end else begin
      dur_d      = '0;
      tone_clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sound_code_q <= SND_NONE;
      prev_code_q  <= SND_NONE;
      erase_q      <= 1'b0;
      erase_prev_q <= 1'b0;
      state_q      <= ST_IDLE;
      code_q       <= SND_NONE;
      dur_q        <= '0;
    end else begin
      sound_code_q <= sound_code;
      prev_code_q  <= sound_code_q;
      erase_q      <= erase_enable;
      erase_prev_q <= erase_q;
      state_q      <= state_d;
      code_q       <= code_d;
      dur_q        <= dur_d;
    end
  end

  tone_gen u_tone_gen (
    .clk         (clk),
    .reset       (reset),
    .clear       (tone_clear),
    .enable      (state_q == ST_PLAY),
    .half_period (hp_sel),
    .wave        (wave)
  );

  assign speaker  = wave;
  assign busy     = (state_q == ST_PLAY);
  assign code_out = code_q;

endmodule

// File: tb/tb_sound_player.sv
// Bench for sound_player: directed scenarios plus random stimulus against a
// tone-timeline model (tone start, elapsed cycles, speaker = (elapsed / HP) mod 2).
module tb_sound_player;

  localparam int CLK_HZ = 26400;
  localparam int TONE   = 600;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sound_code;
  logic       erase_enable;
  logic       speaker;
  logic       busy;
  logic [2:0] code_out;

  int errors = 0;
  int checks = 0;

  // Model: registered view of inputs, pending trigger, current tone timeline.
  logic [2:0] m_sc = 3'd0, m_prev = 3'd0, m_pend_code = 3'd0, m_code = 3'd0;
  logic       m_er = 1'b0, m_er_prev = 1'b0;
  bit         m_pend = 1'b0, m_play = 1'b0;
  int         m_el = 0;

  sound_player #(.CLK_HZ(CLK_HZ), .TONE_CYCLES(TONE)) dut (
    .clk          (clk),
    .reset        (reset),
    .sound_code   (sound_code),
    .erase_enable (erase_enable),
    .speaker      (speaker),
    .busy         (busy),
    .code_out     (code_out)
  );

  always #5 clk = ~clk;

  function automatic int hp_of(input logic [2:0] c);
    case (c)
      3'd1:    return CLK_HZ / (2 * 440);
      3'd2:    return CLK_HZ / (2 * 660);
      3'd3:    return CLK_HZ / (2 * 880);
      default: return CLK_HZ / (2 * 220);
    endcase
  endfunction

  function automatic int dur_of(input logic [2:0] c);
    return (c == 3'd4) ? 4 * TONE : TONE;
  endfunction

  function automatic bit is_tone_code(input logic [2:0] c);
    return (c >= 3'd1) && (c <= 3'd4);
  endfunction

  function automatic bit dut_matches();
    logic [2:0] ec;
    logic       es;
    ec = m_play ? m_code : 3'd0;
    es = m_play ? 1'((m_el / hp_of(m_code)) % 2) : 1'b0;
    return (speaker === es) && (busy === m_play) && (code_out === ec);
  endfunction

  // Advance one clock edge, update the model from the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_sc = 3'd0; m_prev = 3'd0; m_er = 1'b0; m_er_prev = 1'b0;
      m_pend = 1'b0; m_play = 1'b0; m_code = 3'd0; m_el = 0;
    end else begin
      if (m_pend) begin
        m_play = 1'b1; m_code = m_pend_code; m_el = 0;
      end else if (m_play) begin
        m_el++;
        if (m_el == dur_of(m_code)) begin
          m_play = 1'b0; m_code = 3'd0; m_el = 0;
        end
      end
      m_prev = m_sc; m_er_prev = m_er;
      m_sc = sound_code; m_er = erase_enable;
      m_pend = is_tone_code(m_sc) && ((m_sc != m_prev) || (m_er && !m_er_prev));
      m_pend_code = m_sc;
    end
    #1;
  endtask

  task automatic run(input int n, output int mism, output int idle_cyc);
    mism = 0; idle_cyc = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (!dut_matches()) mism++;
      if (busy !== 1'b1) idle_cyc++;
    end
  endtask

  // Follows a tone from its first busy cycle until busy falls (bounded).
  task automatic measure_tone(input int hp, input int chg_at, input logic [2:0] chg_code,
                              input logic chg_erase, output int len, output int togs,
                              output int gaps_bad, output int mism);
    int   t;
    int   last;
    logic prev_spk;
    t = 0; last = 0; len = 1; togs = 0; gaps_bad = 0; mism = 0; prev_spk = speaker;
    while (busy === 1'b1 && t < 3000) begin
      if (t == chg_at) begin
        sound_code = chg_code; erase_enable = chg_erase;
      end
      tick();
      t++;
      if (!dut_matches()) mism++;
      if (busy === 1'b1) begin
        len++;
        if (speaker !== prev_spk) begin
          togs++;
          if (t - last != hp) gaps_bad++;
          last = t;
        end
      end
      prev_spk = speaker;
    end
  endtask

  task automatic test_reset();
    int mism, idle_cyc;
    reset = 1'b1; sound_code = 3'd0; erase_enable = 1'b0;
    repeat (3) tick();
    checks++;
    if ({speaker, busy, code_out} !== 5'b0)
      begin errors++; $display("FAIL reset_hold: spk/busy/code=%b/%b/%0d want 0/0/0", speaker, busy, code_out); end
    reset = 1'b0;
    run(4, mism, idle_cyc);
    checks++;
    if (mism !== 0 || idle_cyc !== 4)
      begin errors++; $display("FAIL reset_idle: mism=%0d idle=%0d want 0/4", mism, idle_cyc); end
  endtask

  task automatic test_basic();
    int len, togs, gaps, mism;
    sound_code = 3'd1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_lat1: busy=%b want 0", busy); end
    tick();
    checks++;
    if (busy !== 1'b1 || code_out !== 3'd1)
      begin errors++; $display("FAIL basic_lat2: busy=%b code=%0d want 1/1", busy, code_out); end
    measure_tone(30, -1, 3'd1, 1'b0, len, togs, gaps, mism);
    checks++;
    if (len !== 600) begin errors++; $display("FAIL basic_len: got %0d want 600", len); end
    checks++;
    if (togs !== 19 || gaps !== 0)
      begin errors++; $display("FAIL basic_wave: toggles=%0d bad_gaps=%0d want 19/0", togs, gaps); end
    checks++;
    if (mism !== 0 || speaker !== 1'b0 || code_out !== 3'd0)
      begin errors++; $display("FAIL basic_model: mism=%0d spk=%b code=%0d want 0/0/0", mism, speaker, code_out); end
  endtask

  task automatic test_erase();
    int len, togs, gaps, mism, idle_cyc;
    sound_code = 3'd3;
    tick(); tick();
    measure_tone(15, -1, 3'd3, 1'b0, len, togs, gaps, mism);
    checks++;
    if (len !== 600 || mism !== 0)
      begin errors++; $display("FAIL erase_pre: len=%0d mism=%0d want 600/0", len, mism); end
    erase_enable = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL erase_lat1: busy=%b want 0", busy); end
    tick();
    checks++;
    if (busy !== 1'b1 || code_out !== 3'd3)
      begin errors++; $display("FAIL erase_lat2: busy=%b code=%0d want 1/3", busy, code_out); end
    measure_tone(15, 48, 3'd3, 1'b0, len, togs, gaps, mism);
    checks++;
    if (len !== 600) begin errors++; $display("FAIL erase_len: got %0d want 600", len); end
    checks++;
    if (togs !== 39 || gaps !== 0 || mism !== 0)
      begin errors++; $display("FAIL erase_wave: toggles=%0d bad_gaps=%0d mism=%0d want 39/0/0", togs, gaps, mism); end
    run(50, mism, idle_cyc);
    checks++;
    if (idle_cyc !== 50 || mism !== 0)
      begin errors++; $display("FAIL erase_single: idle=%0d mism=%0d want 50/0", idle_cyc, mism); end
  endtask

  task automatic test_change_mid();
    int   len, togs, gaps, mism, idle_cyc;
    logic b1;
    sound_code = 3'd1;
    tick(); tick();
    run(298, mism, idle_cyc);
    sound_code = 3'd2;
    tick();
    b1 = busy;
    tick();
    checks++;
    if (idle_cyc !== 0 || b1 !== 1'b1 || busy !== 1'b1 || code_out !== 3'd2 || mism !== 0)
      begin errors++; $display("FAIL change_restart: idle=%0d b1=%b busy=%b code=%0d mism=%0d want 0/1/1/2/0",
                               idle_cyc, b1, busy, code_out, mism); end
    measure_tone(20, -1, 3'd2, 1'b0, len, togs, gaps, mism);
    checks++;
    if (len !== 600) begin errors++; $display("FAIL change_len: got %0d want 600", len); end
    checks++;
    if (togs !== 29 || gaps !== 0 || mism !== 0)
      begin errors++; $display("FAIL change_wave: toggles=%0d bad_gaps=%0d mism=%0d want 29/0/0", togs, gaps, mism); end
  endtask

  task automatic test_lost();
    int len, togs, gaps, mism;
    sound_code = 3'd4;
    tick(); tick();
    checks++;
    if (busy !== 1'b1 || code_out !== 3'd4)
      begin errors++; $display("FAIL lost_start: busy=%b code=%0d want 1/4", busy, code_out); end
    measure_tone(60, 500, 3'd0, 1'b0, len, togs, gaps, mism);
    checks++;
    if (len !== 2400) begin errors++; $display("FAIL lost_len: got %0d want 2400", len); end
    checks++;
    if (togs !== 39 || gaps !== 0 || mism !== 0)
      begin errors++; $display("FAIL lost_wave: toggles=%0d bad_gaps=%0d mism=%0d want 39/0/0", togs, gaps, mism); end
  endtask

  task automatic test_reset_mid();
    int mism, idle_cyc;
    sound_code = 3'd2;
    tick(); tick();
    run(99, mism, idle_cyc);
    checks++;
    if (mism !== 0 || idle_cyc !== 0)
      begin errors++; $display("FAIL rstmid_pre: mism=%0d idle=%0d want 0/0", mism, idle_cyc); end
    reset = 1'b1;
    tick();
    checks++;
    if ({speaker, busy, code_out} !== 5'b0)
      begin errors++; $display("FAIL rstmid_clear: spk/busy/code=%b/%b/%0d want 0/0/0", speaker, busy, code_out); end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || speaker !== 1'b0)
      begin errors++; $display("FAIL rstmid_lat1: busy=%b spk=%b want 0/0", busy, speaker); end
    tick();
    checks++;
    if (busy !== 1'b1 || code_out !== 3'd2 || speaker !== 1'b0)
      begin errors++; $display("FAIL rstmid_retrig: busy=%b code=%0d spk=%b want 1/2/0", busy, code_out, speaker); end
  endtask

  // Retrigger lands on the terminal-count cycle of the running code-2 tone.
  task automatic test_back_to_back();
    int   guard, mism, idle_cyc, len, togs, gaps;
    logic b1;
    guard = 0; mism = 0; idle_cyc = 0;
    while (m_el != TONE - 2 && guard < 2000) begin
      tick();
      guard++;
      if (!dut_matches()) mism++;
      if (busy !== 1'b1) idle_cyc++;
    end
    checks++;
    if (guard >= 2000) begin errors++; $display("FAIL b2b_timeout: waited %0d want <2000", guard); end
    sound_code = 3'd1;
    tick();
    b1 = busy;
    tick();
    checks++;
    if (idle_cyc !== 0 || b1 !== 1'b1 || busy !== 1'b1 || code_out !== 3'd1 || mism !== 0)
      begin errors++; $display("FAIL b2b_restart: idle=%0d b1=%b busy=%b code=%0d mism=%0d want 0/1/1/1/0",
                               idle_cyc, b1, busy, code_out, mism); end
    measure_tone(30, -1, 3'd1, 1'b0, len, togs, gaps, mism);
    checks++;
    if (len !== 600 || mism !== 0)
      begin errors++; $display("FAIL b2b_len: len=%0d mism=%0d want 600/0", len, mism); end
  endtask

  task automatic test_random();
    int mism, busy_cyc;
    mism = 0; busy_cyc = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) sound_code = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) erase_enable = ~erase_enable;
      reset = ($urandom_range(0, 499) == 0);
      tick();
      if (!dut_matches()) mism++;
      if (busy === 1'b1) busy_cyc++;
    end
    reset = 1'b0;
    checks++;
    if (mism !== 0) begin errors++; $display("FAIL random_model: %0d mismatching cycles want 0", mism); end
    checks++;
    if (busy_cyc == 0) begin errors++; $display("FAIL random_activity: busy cycles %0d want >0", busy_cyc); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_erase();
    test_change_mid();
    test_lost();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sound_player.md
SOUND_PLAYER -- requirements
Module: sound_player

Interface
REQ-001 Parameter CLK_HZ, default 25000000, frequency of clk in Hz.
REQ-002 Parameter TONE_CYCLES, default 2500000, tone duration in clk cycles (100 ms at default).
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sound_code  input  3  event code from the ball logic: 1 = top wall or first block hit, 2 = second block hit, 3 = block destroyed, 4 = ball lost; 0 and 5-7 = silent. Synchronous to clk.
REQ-006 erase_enable  input  1  block-hit indication from the ball logic; may be held high for many clk cycles.
REQ-007 speaker  output  1  square-wave audio drive.
REQ-008 busy  output  1  high while a tone is playing.
REQ-009 code_out  output  3  code of the tone currently playing; 0 when idle.

Function
REQ-010 Tone map, half-period HP = CLK_HZ/(2*f), integer floor, computed at elaboration:
- code 1: 440 Hz
- code 2: 660 Hz
- code 3: 880 Hz
- code 4: 220 Hz, at duration 4*TONE_CYCLES
- all other codes: no tone.
REQ-011 Inputs are registered once (sound_code_q, erase_q). Trigger = (sound_code_q != previous sound_code_q and sound_code_q is 1-4) OR (erase_q rising edge and sound_code_q is 1-4).
REQ-012 FSM has 2 states, IDLE and PLAY.
- IDLE -> PLAY on trigger.
- PLAY -> PLAY (restart) on trigger.
- PLAY -> IDLE when the duration counter reaches its terminal count.
REQ-013 On trigger: latch code_out = sound_code_q, clear the duration counter, clear the half-period counter, and drive speaker low. busy and code_out update in the cycle after the registered trigger condition, giving 2 clk cycles of latency from a change on sound_code.
REQ-014 In PLAY, the half-period counter counts 0..HP-1 and speaker toggles on each wrap, so the first toggle occurs HP cycles after entering PLAY.
REQ-015 The duration counter is 26 bits wide and counts 0..D-1, where D = TONE_CYCLES, or 4*TONE_CYCLES for code 4. At D-1: state goes to IDLE, busy = 0, speaker = 0, code_out = 0.
REQ-016 In IDLE, speaker is held at 0 and both counters are held at 0.
REQ-017 The latest trigger always wins. A trigger in the same cycle as terminal count restarts the tone; busy does not drop.
REQ-018 A change of sound_code to 0 or 5-7 does not trigger and does not abort a tone in progress.
REQ-019 An erase_enable level held high for any number of cycles produces exactly one trigger.
REQ-020 The half-period counter is 20 bits wide. An elaboration check requires HP >= 2 for all codes.

Reset
REQ-021 While reset = 1, in the same clk edge:
- state = IDLE; speaker = 0, busy = 0, code_out = 0
- all counters = 0
- sound_code_q = 0, previous code = 0, erase_q = 0
REQ-022 Reset dominates any simultaneous trigger. A tone in progress is abandoned with no further speaker toggles.
REQ-023 After reset is released, a sound_code that is already nonzero and stable triggers exactly once, because the previous code is 0.

Structure
REQ-024 The shared game package holds:
- sound code constants SND_NONE, SND_HIT1, SND_HIT2, SND_BREAK, SND_LOST
- the state encoding for IDLE and PLAY
- tone frequency constants
REQ-025 One sub-module, tone_gen, contains the half-period counter and speaker toggle. It takes inputs clk, reset, clear, enable, and half_period, and outputs wave.
REQ-026 The FSM, the input registers, and the duration counter reside in sound_player. The estimated RTL size is 150-250 lines.

Verification
REQ-027 The bench uses CLK_HZ = 26400 and TONE_CYCLES = 600, giving HP = 30/20/15/60 for codes 1/2/3/4. It covers these scenarios:
- Reset, then sound_code 0 -> 1: busy = 1 and code_out = 1 at cycle 2; speaker toggles every 30 cycles; busy falls after exactly 600 cycles.
- sound_code = 3 held, erase_enable pulsed high for 50 cycles: one restart only; tone lasts 600 cycles with HP = 15.
- Code 1 playing, at cycle 300 sound_code -> 2: restart with HP = 20, busy stays 1 continuously, busy falls 600 cycles after the restart.
- sound_code -> 4: HP = 60; busy lasts 2400 cycles; a later change to 0 does not stop the tone.
- Reset asserted at cycle 100 of a code-2 tone: next cycle speaker = 0, busy = 0, code_out = 0; code held at 2 retriggers after release.
- Trigger coincident with terminal count: busy never drops, and a new 600-cycle tone begins.
